// File: rtl/msg_pkg.sv
// Shared constants and state type for the keypad message buffer.
package msg_pkg;

  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] CHAR_SPACE = 8'h20;

  typedef enum logic {
    EDIT = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/btn_edge.sv
// Per-bit rising-edge detector: one registered previous sample per input bit.
module btn_edge #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] level,
  output logic [W-1:0] rise
);

  logic [W-1:0] prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev <= '0;
    else     prev <= level;
  end

  assign rise = level & ~prev;

endmodule

// File: rtl/msg_buffer.sv
// Keypad message buffer: edits a character line, then streams it out with a terminator.
module msg_buffer
  import msg_pkg::*;
#(
  parameter int         DEPTH     = 16,
  parameter logic [7:0] TERM_CHAR = CHAR_CR
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 char_in,
  input  logic                       char_valid,
  input  logic                       btn_bksp,
  input  logic                       btn_clear,
  input  logic                       btn_send,
  input  logic [$clog2(DEPTH)-1:0]   disp_addr,
  output logic [7:0]                 disp_data,
  output logic [7:0]                 tx_data,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  output logic [$clog2(DEPTH):0]     len,
  output logic                       full,
  output logic                       empty,
  output logic                       busy,
  output logic                       overflow,
  output state_t                     state
);

  localparam int          AW  = $clog2(DEPTH);
  localparam logic [AW:0] CAP = (AW+1)'(DEPTH);

  logic [2:0]  btn_rise;
  logic        bksp_e, clear_e, send_e;
  logic [7:0]  mem [DEPTH];
  logic [AW:0] rd_ptr, rd_next;
  logic        wr_en;

  btn_edge #(.W(3)) u_btn_edge (
    .clk   (clk),
    .rst   (rst),
    .level ({btn_send, btn_clear, btn_bksp}),
    .rise  (btn_rise)
  );

  assign bksp_e  = btn_rise[0];
  assign clear_e = btn_rise[1];
  assign send_e  = btn_rise[2];

  assign full  = (len == CAP);
  assign empty = (len == '0);
  assign busy  = (state == SEND);

  assign rd_next = rd_ptr + 1'b1;
  // A character only lands when no higher-priority event (clear, send) claims the cycle.
  assign wr_en = (state == EDIT) && !clear_e && !send_e && char_valid && (len != CAP);

  always_ff @(posedge clk) begin
    if (wr_en) mem[len[AW-1:0]] <= char_in;
  end

  // Stream handshake: tx_valid/tx_data are held until a clk edge sees tx_valid && tx_ready;
  // that edge is the transfer, and the next byte (or TERM_CHAR) is loaded on it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EDIT;
      len       <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      tx_valid  <= 1'b0;
      tx_data   <= 8'h00;
      disp_data <= CHAR_SPACE;
    end else begin
      disp_data <= ({1'b0, disp_addr} < len) ? mem[disp_addr] : CHAR_SPACE;
      case (state)
        EDIT: begin
          if (clear_e) begin
            len      <= '0;
            overflow <= 1'b0;
          end else if (send_e) begin
            if (len != '0) begin
              state    <= SEND;
              rd_ptr   <= '0;
              tx_valid <= 1'b1;
              tx_data  <= mem[0];
            end
          end else if (char_valid) begin
            if (len != CAP) len      <= len + 1'b1;
            else            overflow <= 1'b1;
          end else if (bksp_e && (len != '0)) begin
            len <= len - 1'b1;
          end
        end
        SEND: begin
          if (char_valid) overflow <= 1'b1;
          if (tx_ready) begin
            if (rd_ptr == len) begin
              state    <= EDIT;
              len      <= '0;
              rd_ptr   <= '0;
              tx_valid <= 1'b0;
            end else begin
              rd_ptr  <= rd_next;
              tx_data <= (rd_next < len) ? mem[rd_next[AW-1:0]] : TERM_CHAR;
            end
          end
        end
        default: state <= EDIT;
      endcase
    end
  end

endmodule
